ha_vector_checker: RTL and testbench

- Consumes stored test vectors, the reading counterpart to the half-adder result-logging flow: applies a/b to an external half adder, samples sum/co, compares against expected bits.
- Emits one result record per vector on a valid/ready stream; keeps pass/fail summary.
- Sits beside the ha instance in self-checking benches and FPGA bring-up.

---
 rtl/ha_vec_pkg.sv | 23 ++
 rtl/ha_vec_mem.sv | 20 ++
 rtl/ha_vector_checker.sv | 120 ++++++++++++
 tb/tb_ha_vector_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ha_vec_pkg.sv
// ha_vec_pkg: shared state encoding and field positions for the half-adder vector checker
// Provides: state_t, bit positions inside wr_data and rec_data, SETTLE_MAX.
package ha_vec_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_SAMPLE,
        S_EMIT,
        S_FIN
    } state_t;
    localparam int WR_SUM    = 0;
    localparam int WR_CO     = 1;
    localparam int WR_B      = 2;
    localparam int WR_A      = 3;
    localparam int REC_MATCH = 0;
    localparam int REC_SUM   = 1;
    localparam int REC_CO    = 2;
    localparam int REC_B     = 3;
    localparam int REC_A     = 4;
    localparam int REC_IDX   = 5;
    localparam int SETTLE_MAX = 15;
endpackage

// File: rtl/ha_vec_mem.sv
// ha_vec_mem: DEPTH x 4 simple dual-port vector RAM, synchronous write, registered read
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata valid one cycle after re.
module ha_vec_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);
    logic [3:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ha_vector_checker.sv
// ha_vector_checker: replays stored vectors into an external half adder and reports per-vector results
// Ports: clk, rst (async high); wr_en/wr_addr/wr_data load vectors {a,b,exp_co,exp_sum};
//   start/num_vec launch a run; dut_a/dut_b drive the adder, dut_sum/dut_co come back;
//   rec_valid/rec_ready/rec_data stream {idx,a,b,co,sum,match}; busy, done, pass,
//   err_count, first_err_idx summarise the run.
import ha_vec_pkg::*;
module ha_vector_checker #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic          start,
    input  logic [AW:0]   num_vec,
    output logic          dut_a,
    output logic          dut_b,
    input  logic          dut_sum,
    input  logic          dut_co,
    output logic          rec_valid,
    input  logic          rec_ready,
    output logic [AW+4:0] rec_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] first_err_idx
);
    state_t        state;
    logic [AW-1:0] idx;
    logic [AW-1:0] last;
    logic [3:0]    cnt;
    logic [3:0]    rd;
    logic [AW:0]   nv;
    logic          hit;
    assign nv  = num_vec > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : num_vec;
    assign hit = dut_co == rd[WR_CO] && dut_sum == rd[WR_SUM];
    ha_vec_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (wr_en && !busy),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (state == S_FETCH),
        .raddr (idx),
        .rdata (rd)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            last          <= '0;
            cnt           <= '0;
            dut_a         <= 1'b0;
            dut_b         <= 1'b0;
            rec_valid     <= 1'b0;
            rec_data      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    err_count     <= '0;
                    first_err_idx <= '0;
                    idx           <= '0;
                    last          <= AW'(nv - 1'b1);
                    if (nv == '0) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state <= S_APPLY;
                    cnt   <= 4'(SETTLE - 1);
                end
                // read word is valid throughout APPLY; the adder sees it from the second APPLY cycle on
                S_APPLY: begin
                    dut_a <= rd[WR_A];
                    dut_b <= rd[WR_B];
                    if (cnt == '0) state <= S_SAMPLE;
                    else cnt <= cnt - 1'b1;
                end
                S_SAMPLE: begin
                    rec_data  <= {idx, rd[WR_A], rd[WR_B], dut_co, dut_sum, hit};
                    rec_valid <= 1'b1;
                    state     <= S_EMIT;
                    if (!hit) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (err_count == '0) first_err_idx <= idx;
                    end
                end
                S_EMIT: if (rec_ready) begin
                    rec_valid <= 1'b0;
                    if (idx == last) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_count == '0;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ha_vector_checker.sv
// tb_ha_vector_checker: randomized self-checking bench against a behavioural vector-run model
module tb_ha_vector_checker;
    localparam int SETTLE = 1;
    localparam int LIMIT  = 2000;
    logic       clk = 0, rst = 1, wr_en = 0, start = 0, rec_ready = 1;
    logic [3:0] wr_addr = 0, wr_data = 0;
    logic [4:0] num_vec = 0;
    logic       dut_a, dut_b, dut_sum, dut_co, rec_valid, busy, done, pass;
    logic [8:0] rec_data;
    logic [4:0] err_count;
    logic [3:0] first_err_idx;
    int n_chk = 0, n_fail = 0;
    int fault = 0;
    int cyc;
    logic [3:0] model_mem [16];
    logic [8:0] got_q[$], exp_q[$];
    int exp_err, exp_first;
    logic [1:0] s;
    ha_vector_checker #(.DEPTH(16), .AW(4), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .num_vec(num_vec), .dut_a(dut_a), .dut_b(dut_b),
        .dut_sum(dut_sum), .dut_co(dut_co), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_data(rec_data), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );
    always #5 clk = ~clk;
    assign s       = 2'(dut_a) + 2'(dut_b);
    assign dut_sum = fault == 2 ? ~s[0] : s[0];
    assign dut_co  = fault == 1 ? 1'b0 : s[1];
    always @(negedge clk) if (rec_valid && rec_ready) got_q.push_back(rec_data);
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input int addr, input logic [3:0] d);
        wr_en = 1; wr_addr = 4'(addr); wr_data = d; model_mem[addr] = d;
        tick();
        wr_en = 0;
    endtask
    task automatic load_random();
        for (int i = 0; i < 16; i++) load(i, 4'($urandom));
    endtask
    task automatic build_exp(input int n);
        int m;
        m = n > 16 ? 16 : n;
        exp_q.delete(); exp_err = 0; exp_first = 0;
        for (int i = 0; i < m; i++) begin
            logic [3:0] w;
            int total;
            logic a, b, co, sm, ok;
            w = model_mem[i];
            a = w[3]; b = w[2];
            total = int'(a) + int'(b);
            sm = fault == 2 ? (total % 2 == 0) : (total % 2 == 1);
            co = fault == 1 ? 1'b0 : (total / 2 == 1);
            ok = co == w[1] && sm == w[0];
            exp_q.push_back({4'(i), a, b, co, sm, ok});
            if (!ok) begin
                if (exp_err == 0) exp_first = i;
                exp_err++;
            end
        end
    endtask
    task automatic check_run();
        check("rec_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("rec_data", got_q[i], exp_q[i]);
        check("done", done, 1);
        check("busy", busy, 0);
        check("err_count", err_count, exp_err);
        check("first_err_idx", first_err_idx, exp_first);
        check("pass", pass, exp_err == 0);
    endtask
    task automatic run(input int n, input bit intrude, output int c);
        got_q.delete(); rec_ready = 1; num_vec = 5'(n); start = 1;
        tick();
        start = 0; wr_en = 0; c = 0;
        while (busy && c < LIMIT) begin
            if (intrude && c == 5) begin
                start = 1; num_vec = 1; wr_en = 1; wr_addr = 3; wr_data = ~model_mem[3];
            end else begin
                start = 0; wr_en = 0;
            end
            tick();
            c++;
        end
        start = 0; wr_en = 0;
        check("no_timeout", c < LIMIT, 1);
        tick();
    endtask
    task automatic run_stall(input int n, input int sidx, input int slen);
        int c;
        logic [8:0] d0;
        got_q.delete(); rec_ready = 0; num_vec = 5'(n); start = 1;
        tick();
        start = 0; c = 0;
        while (busy && c < LIMIT) begin
            if (rec_valid) begin
                d0 = rec_data;
                if (int'(d0[8:5]) == sidx) begin
                    repeat (slen) begin
                        tick();
                        c++;
                        check("stall_valid", rec_valid, 1);
                        check("stall_data", rec_data, d0);
                    end
                end
                rec_ready = 1;
                tick();
                rec_ready = 0;
            end else tick();
            c++;
        end
        check("no_timeout", c < LIMIT, 1);
        tick();
        rec_ready = 1;
    endtask
    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_valid", rec_valid, 0);
        check("rst_err", err_count, 0);
        check("rst_dut_a", dut_a, 0);
        tick(); tick();
        rst = 0;
        tick();
        load(0, 4'b0000); load(1, 4'b0101); load(2, 4'b1001); load(3, 4'b1110);
        fault = 0;
        run(4, 0, cyc);
        check("run_len", cyc, 4 * (SETTLE + 3));
        build_exp(4);
        check_run();
        fault = 1;
        run(4, 0, cyc);
        build_exp(4);
        check_run();
        check("rec3_co0", got_q.size() > 3 ? got_q[3] : 9'h1ff, 9'h078);
        check("first_err3", first_err_idx, 3);
        got_q.delete(); num_vec = 0; start = 1;
        tick();
        start = 0;
        check("zero_done", done, 1);
        check("zero_pass", pass, 1);
        check("zero_busy", busy, 0);
        check("zero_err", err_count, 0);
        tick();
        check("zero_recs", got_q.size(), 0);
        fault = 0;
        run_stall(4, 1, 5);
        build_exp(4);
        check_run();
        load_random();
        run(20, 0, cyc);
        build_exp(20);
        check_run();
        load(0, 4'b1110); load(1, 4'b0101); load(2, 4'b1001); load(3, 4'b1110);
        fault = 1; got_q.delete(); rec_ready = 1; num_vec = 4; start = 1;
        tick();
        start = 0; cyc = 0;
        while (got_q.size() < 2 && cyc < LIMIT) begin tick(); cyc++; end
        check("no_timeout", cyc < LIMIT, 1);
        tick();
        check("pre_rst_err", err_count, 1);
        check("pre_rst_b", dut_b, 1);
        #1 rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", rec_valid, 0);
        check("arst_data", rec_data, 0);
        check("arst_err", err_count, 0);
        check("arst_first", first_err_idx, 0);
        check("arst_dut_b", dut_b, 0);
        check("arst_done", done, 0);
        tick();
        check("arst_recs", got_q.size(), 2);
        rst = 0;
        tick();
        fault = 0;
        run(4, 0, cyc);
        build_exp(4);
        check_run();
        run(4, 1, cyc);
        check("intrude_len", cyc, 4 * (SETTLE + 3));
        build_exp(4);
        check_run();
        run(4, 0, cyc);
        check_run();
        wr_en = 1; wr_addr = 0; wr_data = 4'b1100; model_mem[0] = 4'b1100;
        run(4, 0, cyc);
        build_exp(4);
        check_run();
        for (int k = 0; k < 8; k++) begin
            int n;
            load_random();
            fault = int'($urandom_range(0, 2));
            n = int'($urandom_range(0, 20));
            run_stall(n, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
            build_exp(n);
            check_run();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
